// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot hold-off, load-use stalls, branch squash,
// data-memory freeze, operand forwarding selects and a saturating stall counter.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  de_rs1,
  input  logic [4:0]  de_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        fe_en,
  output logic        de_en,
  output logic        ex_en,
  output logic        pc_r,
  output logic        de_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam logic [BCW-1:0] BOOT_LOAD = BCW'(BOOT_CYCLES);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t         cur_state, nxt_state;
  logic [BCW-1:0] boot_cnt;
  logic           pend_flush, pend_nxt;
  logic           stall_inc;
  logic           mem_block, load_use;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // MEM result wins over WB since it is the younger write; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] m_rd, input logic m_vld, input logic m_wr,
    input logic [4:0] w_rd, input logic w_vld, input logic w_wr
  );
    if (m_vld && m_wr && (m_rd != 5'd0) && (m_rd == rs)) return 2'b01;
    if (w_vld && w_wr && (w_rd != 5'd0) && (w_rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  assign mem_block = dmem_req && !dmem_ack;
  assign load_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == de_rs1) || (ex_rd == de_rs2));

  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_valid, mem_reg_write,
                         wb_rd, wb_valid, wb_reg_write);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_valid, mem_reg_write,
                         wb_rd, wb_valid, wb_reg_write);
  assign state = cur_state;

  always_comb begin
    nxt_state = cur_state;
    pend_nxt  = pend_flush;
    fe_en     = 1'b0;
    de_en     = 1'b0;
    ex_en     = 1'b0;
    pc_r      = 1'b0;
    de_bubble = 1'b0;
    stall_inc = 1'b0;
    case (cur_state)
      BOOT: begin
        pc_r = 1'b1;
        if (boot_cnt <= BCW'(1)) nxt_state = RUN;
      end
      RUN: begin
        if (mem_block) begin
          nxt_state = MEM_WAIT;
          stall_inc = 1'b1;
        end else if (branch_taken) begin
          fe_en     = 1'b1;
          de_en     = 1'b1;
          ex_en     = 1'b1;
          pc_r      = 1'b1;
          nxt_state = FLUSH;
        end else if (load_use) begin
          de_en     = 1'b1;
          ex_en     = 1'b1;
          de_bubble = 1'b1;
          stall_inc = 1'b1;
        end else begin
          fe_en = 1'b1;
          de_en = 1'b1;
          ex_en = 1'b1;
        end
      end
      FLUSH: begin
        // The squash is remembered so it is replayed once memory releases.
        pc_r = 1'b1;
        if (mem_block) begin
          pend_nxt  = 1'b1;
          nxt_state = MEM_WAIT;
        end else begin
          fe_en     = 1'b1;
          de_en     = 1'b1;
          ex_en     = 1'b1;
          nxt_state = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          fe_en     = 1'b1;
          de_en     = 1'b1;
          ex_en     = 1'b1;
          pend_nxt  = 1'b0;
          nxt_state = pend_flush ? FLUSH : RUN;
        end else begin
          stall_inc = 1'b1;
        end
      end
      default: nxt_state = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= BOOT;
      boot_cnt   <= BOOT_LOAD;
      pend_flush <= 1'b0;
      stall_cnt  <= 16'd0;
    end else begin
      cur_state  <= nxt_state;
      pend_flush <= pend_nxt;
      if ((cur_state == BOOT) && (boot_cnt != '0)) boot_cnt <= boot_cnt - BCW'(1);
      if (stall_inc) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the controller.
module tb_hazard_ctrl;

  localparam int BOOT_N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_valid, ex_mem_read, ex_reg_write;
  logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
  logic        branch_taken, dmem_req, dmem_ack;
  logic        fe_en, de_en, ex_en, pc_r, de_bubble;
  logic [1:0]  fwd_a, fwd_b, st;
  logic [15:0] stall_cnt;
  wire  [4:0]  ctl = {fe_en, de_en, ex_en, pc_r, de_bubble};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.BOOT_CYCLES(BOOT_N)) dut (
    .clk(clk), .reset(reset),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .fe_en(fe_en), .de_en(de_en), .ex_en(ex_en), .pc_r(pc_r),
    .de_bubble(de_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(st), .stall_cnt(stall_cnt)
  );

  // Behavioural model: mode 0 boot, 1 run, 2 flush, 3 memory wait.
  int       m_mode, m_elapsed, m_stall;
  bit       m_pend;
  logic     m_blk, m_lu;
  logic [4:0] e_ctl;
  logic [1:0] e_fa, e_fb;

  function automatic logic [1:0] src_of(input logic [4:0] rs,
    input logic [4:0] mr, input logic mv, input logic mw,
    input logic [4:0] wr, input logic wv, input logic ww);
    logic [1:0] r;
    r = 2'b00;
    if (wv && ww && wr != 0 && wr == rs) r = 2'b10;
    if (mv && mw && mr != 0 && mr == rs) r = 2'b01;
    return r;
  endfunction

  always_comb begin
    m_blk = dmem_req && !dmem_ack;
    m_lu  = ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == de_rs1 || ex_rd == de_rs2);
    e_ctl = 5'b00010;
    if (m_mode == 1)
      e_ctl = m_blk ? 5'b00000 : branch_taken ? 5'b11110 : m_lu ? 5'b01101 : 5'b11100;
    else if (m_mode == 2)
      e_ctl = m_blk ? 5'b00010 : 5'b11110;
    else if (m_mode == 3)
      e_ctl = dmem_ack ? 5'b11100 : 5'b00000;
    e_fa = src_of(ex_rs1, mem_rd, mem_valid, mem_reg_write, wb_rd, wb_valid, wb_reg_write);
    e_fb = src_of(ex_rs2, mem_rd, mem_valid, mem_reg_write, wb_rd, wb_valid, wb_reg_write);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_elapsed <= 0; m_pend <= 0; m_stall <= 0;
    end else begin
      if ((m_mode == 1 || m_mode == 3) && !e_ctl[4] && m_stall < 65535) m_stall <= m_stall + 1;
      case (m_mode)
        0: begin
          m_elapsed <= m_elapsed + 1;
          if (m_elapsed + 1 >= BOOT_N) m_mode <= 1;
        end
        1: if (m_blk) m_mode <= 3; else if (branch_taken) m_mode <= 2;
        2: if (m_blk) begin m_pend <= 1; m_mode <= 3; end else m_mode <= 1;
        default: if (dmem_ack) begin m_mode <= m_pend ? 2 : 1; m_pend <= 0; end
      endcase
    end
  end

  task automatic idle();
    de_rs1 = 0; de_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    mem_rd = 0; wb_rd = 0; ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0;
    mem_valid = 0; mem_reg_write = 0; wb_valid = 0; wb_reg_write = 0;
    branch_taken = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    repeat (BOOT_N) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({st, ctl, fwd_a, fwd_b, stall_cnt} !== {2'd0, 5'b00010, 4'b0000, 16'd0})
      $display("FAIL reset_hold: got st=%0d ctl=%b fwd=%b%b stall=%0d want st=0 ctl=00010 fwd=0000 stall=0",
               st, ctl, fwd_a, fwd_b, stall_cnt);
    else n_pass++;
    reset = 0; #1;
    n_checks++;
    if ({st, ctl} !== {2'd0, 5'b00010}) $display("FAIL boot_c1: got st=%0d ctl=%b want 0 00010", st, ctl);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({st, ctl} !== {2'd0, 5'b00010}) $display("FAIL boot_c2: got st=%0d ctl=%b want 0 00010", st, ctl);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({st, ctl, stall_cnt} !== {2'd1, 5'b11100, 16'd0})
      $display("FAIL boot_run: got st=%0d ctl=%b stall=%0d want 1 11100 0", st, ctl, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; de_rs2 = 5; #1;
    n_checks++;
    if ({st, ctl} !== {2'd1, 5'b01101}) $display("FAIL load_use: got st=%0d ctl=%b want 1 01101", st, ctl);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_checks++;
    if ({ctl, stall_cnt} !== {5'b11100, 16'd1}) $display("FAIL load_use_after: got ctl=%b stall=%0d want 11100 1", ctl, stall_cnt);
    else n_pass++;
    ex_valid = 1; ex_mem_read = 1; ex_rd = 0; #1;
    n_checks++;
    if (ctl !== 5'b11100) $display("FAIL load_use_x0: got ctl=%b want 11100", ctl);
    else n_pass++;
    @(negedge clk); ex_rd = 9; de_rs1 = 9; ex_valid = 0; #1;
    n_checks++;
    if ({ctl, stall_cnt} !== {5'b11100, 16'd1}) $display("FAIL load_use_novalid: got ctl=%b stall=%0d want 11100 1", ctl, stall_cnt);
    else n_pass++;
    @(negedge clk); idle();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1; ex_valid = 1; ex_mem_read = 1; ex_rd = 3; de_rs1 = 3; #1;
    n_checks++;
    if ({st, ctl} !== {2'd1, 5'b11110}) $display("FAIL branch_run: got st=%0d ctl=%b want 1 11110", st, ctl);
    else n_pass++;
    @(negedge clk); branch_taken = 0; #1;
    n_checks++;
    if ({st, ctl} !== {2'd2, 5'b11110}) $display("FAIL branch_flush: got st=%0d ctl=%b want 2 11110", st, ctl);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_checks++;
    if ({st, ctl, stall_cnt} !== {2'd1, 5'b11100, 16'd0})
      $display("FAIL branch_done: got st=%0d ctl=%b stall=%0d want 1 11100 0", st, ctl, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1; #1;
    n_checks++;
    if ({st, ctl} !== {2'd1, 5'b00000}) $display("FAIL mem_enter: got st=%0d ctl=%b want 1 00000", st, ctl);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); branch_taken = 1; #1;
      n_checks++;
      if ({st, ctl} !== {2'd3, 5'b00000}) $display("FAIL mem_wait%0d: got st=%0d ctl=%b want 3 00000", i, st, ctl);
      else n_pass++;
    end
    @(negedge clk); dmem_ack = 1; #1;
    n_checks++;
    if ({st, ctl} !== {2'd3, 5'b11100}) $display("FAIL mem_ack: got st=%0d ctl=%b want 3 11100", st, ctl);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_checks++;
    if ({st, ctl, stall_cnt} !== {2'd1, 5'b11100, 16'd3})
      $display("FAIL mem_done: got st=%0d ctl=%b stall=%0d want 1 11100 3", st, ctl, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_mem();
    do_reset();
    branch_taken = 1;
    @(negedge clk); branch_taken = 0; dmem_req = 1; #1;
    n_checks++;
    if ({st, ctl} !== {2'd2, 5'b00010}) $display("FAIL flush_blk: got st=%0d ctl=%b want 2 00010", st, ctl);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({st, ctl} !== {2'd3, 5'b00000}) $display("FAIL flush_wait: got st=%0d ctl=%b want 3 00000", st, ctl);
    else n_pass++;
    @(negedge clk); dmem_ack = 1;
    @(negedge clk); idle(); #1;
    n_checks++;
    if ({st, ctl} !== {2'd2, 5'b11110}) $display("FAIL flush_replay: got st=%0d ctl=%b want 2 11110", st, ctl);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({st, ctl, stall_cnt} !== {2'd1, 5'b11100, 16'd1})
      $display("FAIL flush_done: got st=%0d ctl=%b stall=%0d want 1 11100 1", st, ctl, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_forward();
    do_reset();
    ex_rs1 = 7; mem_rd = 7; wb_rd = 7;
    mem_valid = 1; mem_reg_write = 1; wb_valid = 1; wb_reg_write = 1; #1;
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0100) $display("FAIL fwd_mem: got a=%b b=%b want 01 00", fwd_a, fwd_b);
    else n_pass++;
    mem_reg_write = 0; ex_rs2 = 7; #1;
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) $display("FAIL fwd_wb: got a=%b b=%b want 10 10", fwd_a, fwd_b);
    else n_pass++;
    ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1; #1;
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL fwd_x0: got a=%b b=%b want 00 00", fwd_a, fwd_b);
    else n_pass++;
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    branch_taken = 1;
    @(negedge clk); branch_taken = 0; dmem_req = 1;
    @(negedge clk); #2 reset = 1; #1;
    n_checks++;
    if ({st, ctl, stall_cnt} !== {2'd0, 5'b00010, 16'd0})
      $display("FAIL reset_mid: got st=%0d ctl=%b stall=%0d want 0 00010 0", st, ctl, stall_cnt);
    else n_pass++;
    @(negedge clk); reset = 0; idle();
    repeat (BOOT_N) @(negedge clk);
    dmem_req = 1;
    @(negedge clk); dmem_ack = 1;
    @(negedge clk); idle(); #1;
    n_checks++;
    if ({st, ctl} !== {2'd1, 5'b11100}) $display("FAIL reset_no_pend: got st=%0d ctl=%b want 1 11100", st, ctl);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [38:0] got, want;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      de_rs1 = 5'($urandom_range(0, 3)); de_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      ex_valid = 1'($urandom); ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
      mem_valid = 1'($urandom); mem_reg_write = 1'($urandom);
      wb_valid = 1'($urandom); wb_reg_write = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ack = 1'($urandom);
      #1;
      got  = {st, ctl, fwd_a, fwd_b, stall_cnt, 12'd0};
      want = {2'(m_mode), e_ctl, e_fa, e_fb, 16'(m_stall), 12'd0};
      n_checks++;
      if (got !== want)
        $display("FAIL random[%0d]: got st=%0d ctl=%b fwd=%b%b stall=%0d want st=%0d ctl=%b fwd=%b%b stall=%0d",
                 i, st, ctl, fwd_a, fwd_b, stall_cnt, m_mode, e_ctl, e_fa, e_fb, m_stall);
      else n_pass++;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_flush_mem();
    test_forward();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
